pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_cmp.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding select codes and the default memory-timeout bound.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b01;
    localparam fwd_sel_t FWD_MEMWB = 2'b10;

    localparam int unsigned DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one producer stage's destination register against the ID-stage
// source operands; register 0 is hardwired and never produces a match.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] prod_addr,
    input  logic       prod_we,
    output logic       match_rs,
    output logic       match_rt
);

    logic live;

    always_comb begin
        live     = prod_we && (prod_addr != '0);
        match_rs = live && id_uses_rs && (prod_addr == id_rs);
        match_rt = live && id_uses_rt && (prod_addr == id_rt);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze FSM, branch flush, load-use
// stall and stall counter. Define HAZ_FWD_EN to add operand forwarding selects.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_write_addr,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic [4:0]       mem_write_addr,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic             flush_if,
    output logic             flush_id,
    output logic             mem_err,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
`ifdef HAZ_FWD_EN
    ,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       cooldown;
    logic       mem_op;
    logic       mem_done;
    logic       timeout;
    logic       hz;
    logic       ex_rs, ex_rt, mem_rs, mem_rt;

    hazard_cmp u_cmp_ex (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .prod_addr  (ex_write_addr),
        .prod_we    (ex_reg_write),
        .match_rs   (ex_rs),
        .match_rt   (ex_rt)
    );

    hazard_cmp u_cmp_mem (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .prod_addr  (mem_write_addr),
        .prod_we    (mem_reg_write),
        .match_rs   (mem_rs),
        .match_rt   (mem_rt)
    );

    // The cycle after a completed or aborted access keeps dmem_req low so the
    // finished request is never re-issued while the MEM stage still shows it.
    always_comb begin
        mem_op   = mem_mem_read | mem_mem_write;
        dmem_req = 1'b0;
        timeout  = 1'b0;
        mem_done = 1'b0;
        freeze   = 1'b0;
        if (reset) begin
            if (state == ST_MEM_WAIT) begin
                dmem_req = mem_op;
                timeout  = !dmem_ack && (wait_cnt == WAIT_LAST);
                mem_done = dmem_ack || timeout;
                freeze   = !mem_done;
            end else if (!cooldown) begin
                dmem_req = mem_op;
                mem_done = mem_op && dmem_ack;
                freeze   = mem_op && !dmem_ack;
            end
        end
    end

`ifdef HAZ_FWD_EN
    always_comb begin
        hz    = (ex_rs | ex_rt) & ex_mem_read;
        fwd_a = ex_rs ? FWD_EXMEM : (mem_rs ? FWD_MEMWB : FWD_REG);
        fwd_b = ex_rt ? FWD_EXMEM : (mem_rt ? FWD_MEMWB : FWD_REG);
    end
`else
    always_comb begin
        hz = ex_rs | ex_rt | mem_rs | mem_rt;
    end
`endif

    always_comb begin
        flush_if  = branch_taken & ~freeze;
        flush_id  = branch_taken & ~freeze;
        bubble_ex = hz & ~branch_taken & ~freeze;
        stall_if  = freeze | bubble_ex;
        stall_id  = freeze | bubble_ex;
        mem_err   = timeout;
        busy      = (state == ST_MEM_WAIT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            cooldown  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            cooldown <= mem_done;
            case (state)
                ST_RUN: begin
                    wait_cnt <= '0;
                    if (freeze) state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (mem_done) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
            if (stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
